// File: rtl/fft_deint_frame.sv
// FFT-output deinterleaver: scatters indexed bins into a double-buffered frame and checks lane coverage.
// Define DEINT_ERR_CNT_EN to build the saturating dropped-frame counter behind err_cnt.
module fft_deint_frame #(
   parameter int N_CH    = 8,
   parameter int IDX_W   = $clog2(N_CH),
   parameter int SAMP_W  = 20,
   parameter int TDATA_W = 48,
   parameter int IM_LSB  = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TDATA_W-1:0]       s_tdata,
   input  logic [IDX_W-1:0]         s_tuser,
   input  logic                     s_tvalid,
   input  logic                     s_tlast,
   output logic                     s_tready,
   output logic signed [SAMP_W-1:0] m_real [N_CH],
   output logic signed [SAMP_W-1:0] m_imag [N_CH],
   output logic                     m_frame_valid,
   input  logic                     m_frame_ready,
   output logic [N_CH-1:0]          m_lane_strobe,
   output logic                     err_frame,
   output logic [15:0]              err_cnt
);

   typedef enum logic {ST_FILL, ST_PENDING} ctl_state_t;
   typedef enum logic {RD_EMPTY, RD_FULL} rd_state_t;

   localparam logic [IDX_W:0] LANES = N_CH[IDX_W:0];

   ctl_state_t               state, state_next;
   rd_state_t                rd_state, rd_next;
   logic                     fill_sel;
   logic signed [SAMP_W-1:0] bank_re [2][N_CH];
   logic signed [SAMP_W-1:0] bank_im [2][N_CH];
   logic [N_CH-1:0]          mask, mask_next, hit;
   logic                     dup, dup_next, range_err, range_next;
   logic                     accept, in_range, close, frame_good;
   logic                     release_rd, swap, drop;
   logic                     unused_tdata;

   assign unused_tdata  = ^s_tdata;
   assign accept        = s_tvalid & s_tready;
   assign in_range      = {1'b0, s_tuser} < LANES;
   assign hit           = in_range ? (N_CH'(1) << s_tuser) : '0;
   assign mask_next     = mask | hit;
   assign dup_next      = dup | (|(mask & hit));
   assign range_next    = range_err | ~in_range;
   assign close         = accept & s_tlast;
   assign frame_good    = (&mask_next) & ~dup_next & ~range_next;
   assign release_rd    = (rd_state == RD_FULL) & m_frame_ready;
   assign s_tready      = ~rst & (state == ST_FILL);
   assign m_frame_valid = (rd_state == RD_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FILL;
         rd_state <= RD_EMPTY;
      end else begin
         state    <= state_next;
         rd_state <= rd_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      rd_next    = rd_state;
      swap       = 1'b0;
      drop       = 1'b0;
      if (release_rd) rd_next = RD_EMPTY;
      case (state)
         ST_FILL: begin
            if (close) begin
               if (!frame_good)                             drop = 1'b1;
               else if (rd_state == RD_EMPTY || release_rd) swap = 1'b1;
               else                                         state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (release_rd) begin
               swap       = 1'b1;
               state_next = ST_FILL;
            end
         end
         default: state_next = ST_FILL;
      endcase
      // A swap on the release edge keeps the read bank full with the new frame.
      if (swap) rd_next = RD_FULL;
   end

   // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_sel      <= 1'b0;
         mask          <= '0;
         dup           <= 1'b0;
         range_err     <= 1'b0;
         m_lane_strobe <= '0;
         err_frame     <= 1'b0;
         // NOTE: the banks are reset because the read bank must present zeros out of reset.
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N_CH; k++) begin
               bank_re[b][k] <= '0;
               bank_im[b][k] <= '0;
            end
         end
      end else begin
         m_lane_strobe <= hit & {N_CH{accept}};
         err_frame     <= drop;
         if (accept && in_range) begin
            bank_re[fill_sel][s_tuser] <= s_tdata[SAMP_W-1:0];
            bank_im[fill_sel][s_tuser] <= s_tdata[IM_LSB +: SAMP_W];
         end
         // Coverage is cleared on every close; a pending frame's data stays in its bank.
         if (close) begin
            mask      <= '0;
            dup       <= 1'b0;
            range_err <= 1'b0;
         end else if (accept) begin
            mask      <= mask_next;
            dup       <= dup_next;
            range_err <= range_next;
         end
         if (swap) fill_sel <= ~fill_sel;
      end
   end

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         m_real[k] = bank_re[~fill_sel][k];
         m_imag[k] = bank_im[~fill_sel][k];
      end
   end

`ifdef DEINT_ERR_CNT_EN
   logic [15:0] drop_cnt;

   always_ff @(posedge clk) begin
      if (rst)                               drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end

   assign err_cnt = drop_cnt;
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_deint_frame.sv
// Scoreboard bench for fft_deint_frame: an 8-lane and a 6-lane instance share one stimulus bus.
// Expected strobes and frame/error events are queued by the driver and popped by a monitor.
module tb_fft_deint_frame;

   localparam int SW = 20;
   localparam logic K_FRAME = 1'b0;
   localparam logic K_ERR   = 1'b1;
   localparam int M_GOOD = 0;
   localparam int M_BAD  = 1;
   localparam int M_NONE = 2;

`ifdef DEINT_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic                 dut;
      logic                 kind;
      logic [15:0]          cnt;
      logic [7:0][SW-1:0]   re;
      logic [7:0][SW-1:0]   im;
   } ev_t;

   typedef struct packed {
      logic       dut;
      logic [7:0] strobe;
   } stb_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [47:0]          tdata;
   logic [2:0]           tuser;
   logic                 tvalid, tlast, sel, mon_en;
   logic [1:0]           fr_ready;
   logic                 rdy8, rdy6, v8, v6, err8, err6;
   logic [7:0]           stb8;
   logic [5:0]           stb6;
   logic [15:0]          cnt8, cnt6;
   logic signed [SW-1:0] re8 [8];
   logic signed [SW-1:0] im8 [8];
   logic signed [SW-1:0] re6 [6];
   logic signed [SW-1:0] im6 [6];

   logic [7:0][SW-1:0]   mdl_re, mdl_im;
   int                   bad_cnt [2];
   ev_t                  ev_q [$];
   stb_t                 stb_q [$];
   int                   n_cmp = 0;
   int                   n_fail = 0;

   always #5 clk = ~clk;

   fft_deint_frame #(.N_CH(8)) u_dut8 (
      .clk(clk), .rst(rst), .s_tdata(tdata), .s_tuser(tuser),
      .s_tvalid(tvalid & ~sel), .s_tlast(tlast), .s_tready(rdy8),
      .m_real(re8), .m_imag(im8), .m_frame_valid(v8), .m_frame_ready(fr_ready[0]),
      .m_lane_strobe(stb8), .err_frame(err8), .err_cnt(cnt8)
   );

   fft_deint_frame #(.N_CH(6)) u_dut6 (
      .clk(clk), .rst(rst), .s_tdata(tdata), .s_tuser(tuser),
      .s_tvalid(tvalid & sel), .s_tlast(tlast), .s_tready(rdy6),
      .m_real(re6), .m_imag(im6), .m_frame_valid(v6), .m_frame_ready(fr_ready[1]),
      .m_lane_strobe(stb6), .err_frame(err6), .err_cnt(cnt6)
   );

   function automatic logic [15:0] exp_cnt(input int n);
      if (!CNT_EN) return 16'h0000;
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      ev_t           ev;
      stb_t          st;
      logic [7:0]    s8, s6;
      logic [1:0]    e, h;
      logic [SW-1:0] a_re, a_im;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            s8 = stb8;
            s6 = {2'b00, stb6};
            if (stb_q.size() > 0) begin
               st = stb_q.pop_front();
               check("lane_strobe", st.dut ? s6 : s8, st.strobe);
               check("lane_strobe_other", st.dut ? s8 : s6, 8'h00);
            end else begin
               check("lane_strobe_idle", {s6, s8}, 16'h0000);
            end
            e = {err6, err8};
            h = {v6 & fr_ready[1], v8 & fr_ready[0]};
            for (int d = 0; d < 2; d++) begin
               if (e[d]) begin
                  if (ev_q.size() == 0) check($sformatf("err_frame%0d_expected", d), ev_q.size(), 1);
                  else begin
                     ev = ev_q.pop_front();
                     check($sformatf("err_frame%0d_event", d), {ev.dut, ev.kind}, {1'(d), K_ERR});
                     check($sformatf("err_cnt%0d", d), (d == 0) ? cnt8 : cnt6, ev.cnt);
                  end
               end
               if (h[d]) begin
                  if (ev_q.size() == 0) check($sformatf("frame%0d_expected", d), ev_q.size(), 1);
                  else begin
                     ev = ev_q.pop_front();
                     check($sformatf("frame%0d_event", d), {ev.dut, ev.kind}, {1'(d), K_FRAME});
                     for (int k = 0; k < 8; k++) begin
                        if (d == 0 || k < 6) begin
                           a_re = (d == 0) ? re8[k] : re6[k];
                           a_im = (d == 0) ? im8[k] : im6[k];
                           check($sformatf("frame%0d_real[%0d]", d, k), a_re, ev.re[k]);
                           check($sformatf("frame%0d_imag[%0d]", d, k), a_im, ev.im[k]);
                        end
                     end
                  end
               end
            end
         end
      end
   endtask

   // One sample, accepted on the posedge following a negedge where s_tready is seen high.
   task automatic send(input logic d, input logic [2:0] idx, input logic [SW-1:0] re,
                       input logic [SW-1:0] im, input logic last);
      int   waited = 0;
      stb_t st;
      sel = d;
      forever begin
         @(negedge clk);
         if (((d == 1'b0) ? rdy8 : rdy6) === 1'b1) break;
         waited++;
         if (waited > 200) begin
            check("s_tready_timeout", (d == 1'b0) ? rdy8 : rdy6, 1);
            return;
         end
      end
      tuser  = idx;
      tdata  = {4'hA, im, 4'h5, re};
      tlast  = last;
      tvalid = 1'b1;
      @(posedge clk);
      st.dut    = d;
      st.strobe = (int'(idx) < ((d == 1'b0) ? 8 : 6)) ? (8'h01 << idx) : 8'h00;
      stb_q.push_back(st);
      #1 tvalid = 1'b0;
   endtask

   task automatic frame(input logic d, input logic [7:0][2:0] idxs, input int n,
                        input int re_base, input int re_step, input int im_base,
                        input int im_step, input int mode);
      logic [2:0]    idx;
      logic [SW-1:0] re, im;
      ev_t           ev;
      for (int j = 0; j < n; j++) begin
         idx = idxs[j];
         re  = SW'(re_base + int'(idx) * re_step);
         im  = SW'(im_base + int'(idx) * im_step);
         mdl_re[idx] = re;
         mdl_im[idx] = im;
         send(d, idx, re, im, (j == n - 1) && (mode != M_NONE));
      end
      ev     = '0;
      ev.dut = d;
      if (mode == M_GOOD) begin
         ev.kind = K_FRAME;
         ev.re   = mdl_re;
         ev.im   = mdl_im;
         ev_q.push_back(ev);
      end else if (mode == M_BAD) begin
         bad_cnt[d]++;
         ev.kind = K_ERR;
         ev.cnt  = exp_cnt(bad_cnt[d]);
         ev_q.push_back(ev);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, v8, 0);
      check({tag, "_strobe"}, stb8, 0);
      check({tag, "_err_frame"}, err8, 0);
      check({tag, "_err_cnt"}, cnt8, 0);
      check({tag, "_tready"}, rdy8, 1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_real[%0d]", tag, k), {re8[k]}, 0);
         check($sformatf("%s_imag[%0d]", tag, k), {im8[k]}, 0);
      end
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: run did not finish within its cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      tvalid   = 1'b0;
      tlast    = 1'b0;
      tuser    = '0;
      tdata    = '0;
      sel      = 1'b0;
      fr_ready = 2'b11;
      mon_en   = 1'b0;
      mdl_re   = '0;
      mdl_im   = '0;
      bad_cnt  = '{0, 0};
      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("tready_in_reset8", rdy8, 0);
      check("tready_in_reset6", rdy6, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("por");
      mon_en = 1'b1;

      // In-order frame: real = k*1000, imag = -k.
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 0, 1000, 0, -1, M_GOOD);
      @(negedge clk);
      check("valid_after_close", v8, 1);

      // Permuted order, most-negative real.
      frame(0, {3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd0, 3'd3, 3'd7}, 8, -524288, 0, 524287, -1, M_GOOD);

      // Duplicate lane 3, then a short frame.
      frame(0, {3'd7, 3'd6, 3'd5, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 11, 1, 22, 1, M_BAD);
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 6, 33, 1, 44, 1, M_BAD);

      // Back-pressure: three good frames against a stalled consumer.
      @(posedge clk);
      #1 fr_ready[0] = 1'b0;
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 100, 1, 200, 1, M_GOOD);
      frame(0, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8, 300, 3, 400, -3, M_GOOD);
      @(negedge clk);
      check("tready_pending", rdy8, 0);
      check("valid_held", v8, 1);
      @(posedge clk);
      #1 fr_ready[0] = 1'b1;
      @(posedge clk);
      #1 fr_ready[0] = 1'b0;
      @(negedge clk);
      check("tready_after_release", rdy8, 1);
      check("valid_after_release", v8, 1);
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 500, 5, 600, -5, M_GOOD);
      @(negedge clk);
      check("tready_pending_f3", rdy8, 0);
      @(posedge clk);
      #1 fr_ready[0] = 1'b1;
      repeat (3) @(posedge clk);

      // Six-lane instance: out-of-range index 7, then a good reversed frame.
      frame(1, {3'd0, 3'd5, 3'd4, 3'd3, 3'd7, 3'd2, 3'd1, 3'd0}, 7, 7, 1, 8, 1, M_BAD);
      frame(1, {3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}, 6, -1000, -7, 3000, 9, M_GOOD);

      // Reset in the middle of a frame, then a full good frame.
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3, 9, 1, 9, 1, M_NONE);
      #1 rst = 1'b1;
      @(negedge clk);
      check("tready_mid_reset", rdy8, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bad_cnt = '{0, 0};
      @(negedge clk);
      check_reset_outputs("mid");
      frame(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 1234, 11, -55, 13, M_GOOD);

`ifdef DEINT_ERR_CNT_EN
      for (int i = 0; i < 65537; i++) begin
         frame(0, '0, 1, i, 0, 0, 0, M_BAD);
      end
      @(negedge clk);
      check("err_cnt_saturated", cnt8, 16'hFFFF);
`endif

      for (int i = 0; i < 20 && (ev_q.size() != 0 || stb_q.size() != 0); i++) @(negedge clk);
      check("events_pending", ev_q.size(), 0);
      check("strobes_pending", stb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
